// File: rtl/parity_serializer_pkg.sv
// parity_pkg: shared types for the serial parity link (serializer and checker side).
// Holds the frame FSM state enum and the EVEN/ODD parity selector constants.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam bit EVEN = 1'b0;
  localparam bit ODD  = 1'b1;

endpackage

// File: rtl/parity_serializer_if.sv
// parity_serializer_if: parallel-load / serial-out bundle of the parity serializer.
// master: load, data_in -> ; <- ready, x, bit_valid, last.  slave: the reverse.
interface parity_serializer_if #(
  parameter int DATA_W = 8
);

  logic              load;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              x;
  logic              bit_valid;
  logic              last;

  modport master (
    output load, data_in,
    input  ready, x, bit_valid, last
  );

  modport slave (
    input  load, data_in,
    output ready, x, bit_valid, last
  );

endinterface

// File: rtl/parity_serializer_acc.sv
// parity_acc: running XOR accumulator, shared by serializer and checker.
// Ports: clk, reset (async high), clr (sync clear), en, bit_in -> par.
module parity_acc (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic par
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      par <= 1'b0;
    else if (clr)
      par <= 1'b0;
    else if (en)
      par <= par ^ bit_in;
  end

endmodule

// File: rtl/parity_serializer.sv
// parity_serializer: shifts a parallel word out LSB first, then a parity bit.
// Ports: clk, reset (async high), bus (slave: load/data_in in; ready/x/bit_valid/last out).
// Option macro PARITY_SER_STOP_BIT_EN appends a stop bit (x=1) after parity.
module parity_serializer
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input logic                 clk,
  input logic                 reset,
  parity_serializer_if.slave  bus
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

`ifdef PARITY_SER_STOP_BIT_EN
  localparam state_t FINAL = STOP;
`else
  localparam state_t FINAL = PARITY;
`endif

  state_t            state;
  state_t            nstate;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nx;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic              accept;
  logic              in_data;
  logic              acc;
  logic              par_nx;

  logic x_nx, valid_nx, last_nx, ready_nx;
  logic x_q, valid_q, last_q, ready_q;

  assign accept  = bus.load & ready_q;
  assign in_data = (state == DATA);

  parity_acc u_acc (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .en     (in_data),
    .bit_in (shreg[0]),
    .par    (acc)
  );

  // Parity including the bit being shifted out on this edge.
  assign par_nx = acc ^ (in_data & shreg[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= nstate;
      shreg <= shreg_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:   if (accept) nstate = DATA;
      DATA:   if (cnt == CNT_LAST) nstate = PARITY;
`ifdef PARITY_SER_STOP_BIT_EN
      PARITY: nstate = STOP;
`else
      PARITY: nstate = accept ? DATA : IDLE;
`endif
      STOP:   nstate = accept ? DATA : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    shreg_nx = shreg;
    cnt_nx   = cnt;
    if (accept) begin
      shreg_nx = bus.data_in;
      cnt_nx   = '0;
    end else if (in_data) begin
      shreg_nx = shreg >> 1;
      cnt_nx   = cnt + 1'b1;
    end
  end

  // Outputs are precomputed from the next state so the registered
  // bit appears in the same cycle as the state it belongs to.
  always_comb begin
    x_nx     = 1'b0;
    valid_nx = 1'b1;
    last_nx  = (nstate == FINAL);
    ready_nx = (nstate == FINAL);
    unique case (1'b1)
      (nstate == IDLE): begin
        valid_nx = 1'b0;
        ready_nx = 1'b1;
      end
      (nstate == DATA):   x_nx = shreg_nx[0];
      (nstate == PARITY): x_nx = par_nx ^ ODD_PARITY;
      (nstate == STOP):   x_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      x_q     <= x_nx;
      valid_q <= valid_nx;
      last_q  <= last_nx;
      ready_q <= ready_nx;
    end
  end

  assign bus.x         = x_q;
  assign bus.bit_valid = valid_q;
  assign bus.last      = last_q;
  assign bus.ready     = ready_q;

endmodule
